// File: rtl/cal_core_mac_gen_if.sv
// ============================================================================
// Module : cal_core_mac_gen_if
// Desc   : Stream bundle for cal_core_mac_gen (vinput, M rows, beta, error).
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface cal_core_mac_gen_if #(
  parameter int A  = 4,
  parameter int VW = 32,
  parameter int MW = 8,
  parameter int BW = 8
) ();
  logic [VW-1:0]   vin_data;
  logic            vin_valid;
  logic            vin_last;
  logic            vin_ready;
  logic [A*MW-1:0] m_data;
  logic            m_valid;
  logic            m_last;
  logic            m_ready;
  logic [A*BW-1:0] beta;
  logic            beta_valid;
  logic            beta_ready;
  logic            frame_err;

  modport master (
    output vin_data, vin_valid, vin_last,
    input  vin_ready,
    output m_data, m_valid, m_last,
    input  m_ready,
    input  beta, beta_valid,
    output beta_ready,
    input  frame_err
  );

  modport slave (
    input  vin_data, vin_valid, vin_last,
    output vin_ready,
    input  m_data, m_valid, m_last,
    output m_ready,
    output beta, beta_valid,
    input  beta_ready,
    output frame_err
  );
endinterface

`default_nettype wire

// File: rtl/cal_core_mac_gen.sv
// ============================================================================
// Module : cal_core_mac_gen
// Desc   : A-lane streaming MAC/beta core with vinput/M alignment FIFOs,
//          tlast cross-check and held beta output. Define CAL_CORE_MAC_SAT_EN
//          to saturate beta lanes instead of wrapping.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cal_core_mac_gen #(
  parameter int A     = 4,
  parameter int VW    = 32,
  parameter int MW    = 8,
  parameter int ACCW  = 48,
  parameter int BW    = 8,
  parameter int SHIFT = 0,
  parameter int DEPTH = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  cal_core_mac_gen_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = VW + MW;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t r_state, w_state_nx;

  // vinput FIFO: entry = {last, data}
  logic [VW:0]     r_vmem [DEPTH];
  logic [AW:0]     r_vwp, r_vrp;
  logic            w_v_full, w_v_empty, w_v_push, w_v_pop;
  logic [VW:0]     w_v_head;
  logic [VW-1:0]   w_v_hdata;
  logic            w_v_hlast;

  // M-row FIFO: entry = {last, row}
  logic [A*MW:0]   r_mmem [DEPTH];
  logic [AW:0]     r_mwp, r_mrp;
  logic            w_m_full, w_m_empty, w_m_push, w_m_pop;
  logic [A*MW:0]   w_m_head;
  logic [A*MW-1:0] w_m_hdata;
  logic            w_m_hlast;

  logic                   w_take, w_err, w_load, w_release;
  logic                   r_drain_cnt, r_flush_m;
  logic                   r_p1_valid;
  logic signed [PW-1:0]   w_prod [A];
  logic signed [PW-1:0]   r_prod [A];
  logic signed [ACCW-1:0] r_acc  [A];
  logic [A*BW-1:0]        w_beta_nx, r_beta;
  logic                   r_beta_valid, r_frame_err;

  // Full/empty come from registered pointers only, so a same-cycle pop never frees a slot.
  assign w_v_full  = (r_vwp[AW] != r_vrp[AW]) && (r_vwp[AW-1:0] == r_vrp[AW-1:0]);
  assign w_v_empty = (r_vwp == r_vrp);
  assign w_v_push  = bus.vin_valid & ~w_v_full;
  assign w_v_head  = r_vmem[r_vrp[AW-1:0]];
  assign w_v_hdata = w_v_head[VW-1:0];
  assign w_v_hlast = w_v_head[VW];

  assign w_m_full  = (r_mwp[AW] != r_mrp[AW]) && (r_mwp[AW-1:0] == r_mrp[AW-1:0]);
  assign w_m_empty = (r_mwp == r_mrp);
  assign w_m_push  = bus.m_valid & ~w_m_full;
  assign w_m_head  = r_mmem[r_mrp[AW-1:0]];
  assign w_m_hdata = w_m_head[A*MW-1:0];
  assign w_m_hlast = w_m_head[A*MW];

  always_ff @(posedge clk) begin
    if (w_v_push) r_vmem[r_vwp[AW-1:0]] <= {bus.vin_last, bus.vin_data};
    if (w_m_push) r_mmem[r_mwp[AW-1:0]] <= {bus.m_last, bus.m_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vwp <= '0;
      r_vrp <= '0;
      r_mwp <= '0;
      r_mrp <= '0;
    end else begin
      if (w_v_push) r_vwp <= r_vwp + 1'b1;
      if (w_v_pop)  r_vrp <= r_vrp + 1'b1;
      if (w_m_push) r_mwp <= r_mwp + 1'b1;
      if (w_m_pop)  r_mrp <= r_mrp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACC;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_v_pop    = 1'b0;
    w_m_pop    = 1'b0;
    w_take     = 1'b0;
    w_err      = 1'b0;
    w_load     = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      ST_ACC: begin
        if (!w_v_empty && !w_m_empty) begin
          w_v_pop = 1'b1;
          w_m_pop = 1'b1;
          if (w_v_hlast != w_m_hlast) begin
            w_err      = 1'b1;
            w_state_nx = ST_FLUSH;
          end else begin
            w_take = 1'b1;
            if (w_v_hlast) w_state_nx = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt) begin
          w_load     = 1'b1;
          w_state_nx = ST_OUT;
        end
      end
      ST_OUT: begin
        if (r_beta_valid && bus.beta_ready) begin
          w_release  = 1'b1;
          w_state_nx = ST_ACC;
        end
      end
      ST_FLUSH: begin
        // Only the stream that was still mid-frame is drained to its boundary.
        if (r_flush_m) begin
          if (!w_m_empty) begin
            w_m_pop = 1'b1;
            if (w_m_hlast) w_state_nx = ST_ACC;
          end
        end else begin
          if (!w_v_empty) begin
            w_v_pop = 1'b1;
            if (w_v_hlast) w_state_nx = ST_ACC;
          end
        end
      end
      default: w_state_nx = ST_ACC;
    endcase
  end

`ifdef CAL_CORE_MAC_SAT_EN
  localparam logic signed [ACCW-1:0] c_max = {{(ACCW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] c_min = {{(ACCW-BW+1){1'b1}}, {(BW-1){1'b0}}};
`endif

  for (genvar a = 0; a < A; a++) begin : g_lane
    logic [MW-1:0] w_m_lane;
    assign w_m_lane  = w_m_hdata[a*MW +: MW];
    assign w_prod[a] = {{MW{w_v_hdata[VW-1]}}, w_v_hdata} * {{VW{w_m_lane[MW-1]}}, w_m_lane};
`ifdef CAL_CORE_MAC_SAT_EN
    logic signed [ACCW-1:0] w_sh;
    assign w_sh = r_acc[a] >>> SHIFT;
    assign w_beta_nx[a*BW +: BW] = (w_sh > c_max) ? c_max[BW-1:0] :
                                   (w_sh < c_min) ? c_min[BW-1:0] : w_sh[BW-1:0];
`else
    assign w_beta_nx[a*BW +: BW] = BW'(r_acc[a] >>> SHIFT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_valid   <= 1'b0;
      r_drain_cnt  <= 1'b0;
      r_flush_m    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_beta       <= '0;
      r_beta_valid <= 1'b0;
      for (int a = 0; a < A; a++) begin
        r_prod[a] <= '0;
        r_acc[a]  <= '0;
      end
    end else begin
      r_p1_valid  <= w_take;
      r_frame_err <= w_err;
      r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
      if (w_err) r_flush_m <= ~w_m_hlast;
      for (int a = 0; a < A; a++) begin
        if (w_take) r_prod[a] <= w_prod[a];
        // A mismatch discards the whole partial frame, including an in-flight product.
        if (w_err || w_release) r_acc[a] <= '0;
        else if (r_p1_valid)    r_acc[a] <= r_acc[a] + ACCW'(r_prod[a]);
      end
      if (w_load) begin
        r_beta       <= w_beta_nx;
        r_beta_valid <= 1'b1;
      end else if (w_release) begin
        r_beta_valid <= 1'b0;
      end
    end
  end

  assign bus.vin_ready  = ~w_v_full;
  assign bus.m_ready    = ~w_m_full;
  assign bus.beta       = r_beta;
  assign bus.beta_valid = r_beta_valid;
  assign bus.frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_cal_core_mac_gen.sv
// Directed bench for cal_core_mac_gen: a frame-level reference model feeds an
// expected-beta queue checked every cycle, plus hand-computed literal results.
`default_nettype none
`timescale 1ns/1ps

module tb_cal_core_mac_gen;
  localparam int A = 4, VW = 32, MW = 8, ACCW = 48, BW = 8, SHIFT = 0, DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cal_core_mac_gen_if #(.A(A), .VW(VW), .MW(MW), .BW(BW)) bus ();

  cal_core_mac_gen #(.A(A), .VW(VW), .MW(MW), .ACCW(ACCW), .BW(BW),
                     .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [VW-1:0] d; bit last; } v_ent_t;
  typedef struct { logic [A*MW-1:0] d; bit last; } m_ent_t;

  v_ent_t svq[$], vq[$];
  m_ent_t smq[$], mq[$];
  logic [A*BW-1:0] exp_q[$];
  longint macc [A];
  bit flushing = 0, flush_m = 0;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, v_cnt = 0, m_cnt = 0, v_wcyc = 0, m_wcyc = 0;
  int n_beta = 0, n_ferr = 0, exp_ferr = 0;
  logic [A*BW-1:0] last_beta = '0, prev_beta = '0;
  bit prev_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [A*BW-1:0] reduce_acc();
    logic [A*BW-1:0] r;
    longint s;
    for (int a = 0; a < A; a++) begin
      s = (macc[a] <<< (64 - ACCW)) >>> (64 - ACCW);
      s = s >>> SHIFT;
`ifdef CAL_CORE_MAC_SAT_EN
      if (s > (64'sd1 <<< (BW - 1)) - 1) s = (64'sd1 <<< (BW - 1)) - 1;
      if (s < -(64'sd1 <<< (BW - 1)))    s = -(64'sd1 <<< (BW - 1));
`endif
      r[a*BW +: BW] = s[BW-1:0];
    end
    return r;
  endfunction

  // Frame-level model: pair entries in order, emit on joint last, flush on disagreement.
  task automatic model_run();
    v_ent_t ve;
    m_ent_t me;
    logic signed [MW-1:0] ml;
    forever begin
      if (!flushing) begin
        if (vq.size() == 0 || mq.size() == 0) break;
        ve = vq.pop_front();
        me = mq.pop_front();
        if (ve.last != me.last) begin
          exp_ferr++;
          for (int a = 0; a < A; a++) macc[a] = 0;
          flushing = 1;
          flush_m  = !me.last;
        end else begin
          for (int a = 0; a < A; a++) begin
            ml = me.d[a*MW +: MW];
            macc[a] += longint'($signed(ve.d)) * longint'(ml);
          end
          if (ve.last) begin
            exp_q.push_back(reduce_acc());
            for (int a = 0; a < A; a++) macc[a] = 0;
          end
        end
      end else if (flush_m) begin
        if (mq.size() == 0) break;
        me = mq.pop_front();
        if (me.last) flushing = 0;
      end else begin
        if (vq.size() == 0) break;
        ve = vq.pop_front();
        if (ve.last) flushing = 0;
      end
    end
  endtask

  always @(negedge clk) if (rst_n) model_run();

  // Compare process: every cycle beta_valid is high, and hold stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 0;
    end else begin
      if (bus.frame_err) n_ferr++;
      if (bus.beta_valid) begin
        if (exp_q.size() == 0)
          check(1'b0, "unexpected_beta", bus.beta, 0);
        else
          check(bus.beta == exp_q[0], "beta_vs_model", bus.beta, exp_q[0]);
        if (prev_hold)
          check(bus.beta == prev_beta, "beta_stable_in_stall", bus.beta, prev_beta);
        if (bus.beta_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          last_beta = bus.beta;
          n_beta++;
        end
      end
      prev_hold = bus.beta_valid && !bus.beta_ready;
      prev_beta = bus.beta;
    end
  end

  task automatic push_v(input v_ent_t e);
    int k = 0;
    bit ok = 0;
    bus.vin_data = e.d; bus.vin_last = e.last; bus.vin_valid = 1'b1;
    while (!ok && k < 200) begin
      @(negedge clk); ok = bus.vin_ready;
      @(posedge clk); #1; k++;
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL vin_push_timeout: vin_ready low for %0d cycles, required high within 200", k);
    end else begin
      vq.push_back(e); v_cnt++; v_wcyc = cyc;
    end
  endtask

  task automatic push_m(input m_ent_t e);
    int k = 0;
    bit ok = 0;
    bus.m_data = e.d; bus.m_last = e.last; bus.m_valid = 1'b1;
    while (!ok && k < 200) begin
      @(negedge clk); ok = bus.m_ready;
      @(posedge clk); #1; k++;
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL m_push_timeout: m_ready low for %0d cycles, required high within 200", k);
    end else begin
      mq.push_back(e); m_cnt++; m_wcyc = cyc;
    end
  endtask

  task automatic add_v(input logic [VW-1:0] d, input bit l);
    v_ent_t e; e.d = d; e.last = l; svq.push_back(e);
  endtask

  task automatic add_m(input logic [A*MW-1:0] d, input bit l);
    m_ent_t e; e.d = d; e.last = l; smq.push_back(e);
  endtask

  task automatic run_streams();
    fork
      begin
        for (int i = 0; i < svq.size(); i++) push_v(svq[i]);
        bus.vin_valid = 1'b0;
      end
      begin
        for (int j = 0; j < smq.size(); j++) push_m(smq[j]);
        bus.m_valid = 1'b0;
      end
    join
    svq.delete();
    smq.delete();
  endtask

  task automatic wait_beta(input int start, input string name);
    int k = 0;
    while (!bus.beta_valid && k < 60) begin @(posedge clk); #1; k++; end
    check(bus.beta_valid && (cyc - start) == 3, name, cyc - start, 3);
  endtask

  task automatic wait_idle();
    int k = 0;
    repeat (2) @(posedge clk);
    #1;
    while ((exp_q.size() != 0 || bus.beta_valid) && k < 400) begin @(posedge clk); #1; k++; end
    if (k >= 400) begin
      n_checks++; n_errors++;
      $display("FAIL idle_timeout: %0d betas still pending after 400 cycles, required 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int v0, m0, b0, f0;
    bus.vin_data = '0; bus.vin_valid = 1'b0; bus.vin_last = 1'b0;
    bus.m_data = '0; bus.m_valid = 1'b0; bus.m_last = 1'b0;
    bus.beta_ready = 1'b1;
    for (int a = 0; a < A; a++) macc[a] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check(bus.beta_valid == 1'b0, "reset_beta_valid", bus.beta_valid, 0);
    check(bus.beta == '0, "reset_beta", bus.beta, 0);
    check(bus.frame_err == 1'b0, "reset_frame_err", bus.frame_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check(bus.vin_ready == 1'b1, "reset_vin_ready", bus.vin_ready, 1);
    check(bus.m_ready == 1'b1, "reset_m_ready", bus.m_ready, 1);

    // Basic frame: vin 1,2,3; lanes 1,-1,2,10
    add_v(1, 0); add_v(2, 0); add_v(3, 1);
    for (int i = 0; i < 3; i++) add_m({8'd10, 8'd2, 8'hFF, 8'd1}, i == 2);
    run_streams();
    wait_beta((v_wcyc > m_wcyc) ? v_wcyc : m_wcyc, "basic_latency");
    wait_idle();
    check(last_beta == 32'h3C0CFA06, "basic_beta", last_beta, 32'h3C0CFA06);

    // Saturation / wrap
    add_v(100, 1); add_m({4{8'd100}}, 1);
    run_streams();
    wait_idle();
`ifdef CAL_CORE_MAC_SAT_EN
    check(last_beta == 32'h7F7F7F7F, "sat_beta", last_beta, 32'h7F7F7F7F);
`else
    check(last_beta == 32'h10101010, "wrap_beta", last_beta, 32'h10101010);
`endif

    // tlast mismatch: vin_last on pair 2, m_last on pair 3, then a clean frame
    f0 = n_ferr; b0 = n_beta;
    add_v(7, 0); add_v(8, 1); add_v(2, 1);
    add_m({4{8'd1}}, 0); add_m({4{8'd2}}, 0); add_m({4{8'd5}}, 1); add_m({4{8'd3}}, 1);
    run_streams();
    wait_idle();
    check((n_ferr - f0) == 1, "mismatch_err_pulses", n_ferr - f0, 1);
    check((n_beta - b0) == 1, "mismatch_beta_count", n_beta - b0, 1);
    check(last_beta == 32'h06060606, "mismatch_next_beta", last_beta, 32'h06060606);

    // Back-pressure: 12 two-pair frames with beta_ready low for 40 cycles
    v0 = v_cnt; m0 = m_cnt; b0 = n_beta;
    bus.beta_ready = 1'b0;
    for (int f = 0; f < 12; f++)
      for (int i = 0; i < 2; i++) begin
        add_v(VW'(f * 3 + i - 5), i == 1);
        add_m({8'(f + i + 1), 8'(f + i), 8'(f + i - 1), 8'(f + i - 2)}, i == 1);
      end
    fork
      run_streams();
      begin
        repeat (35) @(posedge clk);
        #1;
        check(bus.vin_ready == 1'b0, "stall_vin_ready", bus.vin_ready, 0);
        check(bus.m_ready == 1'b0, "stall_m_ready", bus.m_ready, 0);
        check((v_cnt - v0) == 18, "stall_vin_accepted", v_cnt - v0, 18);
        check((m_cnt - m0) == 18, "stall_m_accepted", m_cnt - m0, 18);
        repeat (5) @(posedge clk);
        #1;
        bus.beta_ready = 1'b1;
      end
    join
    wait_idle();
    check((n_beta - b0) == 12, "stall_beta_count", n_beta - b0, 12);

    // Reset mid-frame: 2 pairs popped, 2 more vin queued
    add_v(1, 0); add_v(2, 0); add_m({4{8'd1}}, 0); add_m({4{8'd2}}, 0);
    run_streams();
    add_v(3, 0); add_v(4, 1);
    run_streams();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    vq.delete(); mq.delete(); exp_q.delete();
    for (int a = 0; a < A; a++) macc[a] = 0;
    flushing = 0;
    #2;
    check(bus.beta_valid == 1'b0, "midreset_beta_valid", bus.beta_valid, 0);
    check(bus.frame_err == 1'b0, "midreset_frame_err", bus.frame_err, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check(bus.vin_ready && bus.m_ready, "midreset_ready", {bus.vin_ready, bus.m_ready}, 2'b11);
    add_v(5, 1); add_m({4{8'd1}}, 1);
    run_streams();
    wait_idle();
    check(last_beta == 32'h05050505, "midreset_beta", last_beta, 32'h05050505);

    // Skewed arrival: M row 10 cycles after vin
    add_v(-7, 1);
    run_streams();
    repeat (10) @(posedge clk);
    #1;
    check(bus.beta_valid == 1'b0, "skew_no_early_beta", bus.beta_valid, 0);
    add_m({8'hFC, 8'd3, 8'd2, 8'd1}, 1);
    run_streams();
    wait_beta(m_wcyc, "skew_latency");
    wait_idle();
    check(last_beta == 32'h1CEBF2F9, "skew_beta", last_beta, 32'h1CEBF2F9);

    check(n_ferr == exp_ferr, "frame_err_total", n_ferr, exp_ferr);
    check(exp_q.size() == 0, "no_pending_beta", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/cal_core_mac_gen.md
# cal_core_mac_gen

Parametrised streaming MAC/beta core for the `cal_core` family. It generalises the fixed 4-lane, 8-bit MAC stage to A lanes with configurable input, accumulator and output widths. It adds valid/ready back-pressure on every port, internal alignment FIFOs, per-frame tlast cross-checking with error recovery, and a registered, held beta output. It sits after the vinput and M-row generators and produces one beta vector per frame.

## Interface
- `A`, 4, number of M lanes (beta lanes)
- `VW`, 32, vinput width, signed
- `MW`, 8, M lane width, signed
- `ACCW`, 48, accumulator width per lane, signed; must be ≥ VW+MW
- `BW`, 8, beta lane width, signed
- `SHIFT`, 0, arithmetic right shift applied to the accumulator before output
- `DEPTH`, 16, depth of each input FIFO; power of 2, ≥ 2

- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `vin_data` in VW — vinput sample
- `vin_valid` in 1 — vinput valid
- `vin_last` in 1 — last vinput of frame
- `vin_ready` out 1 — vinput FIFO not full
- `m_data` in A*MW — M row; lane a at `[a*MW +: MW]`
- `m_valid` in 1 — M row valid
- `m_last` in 1 — last M row of frame
- `m_ready` out 1 — M FIFO not full
- `beta` out A*BW — result; lane a at `[a*BW +: BW]`
- `beta_valid` out 1 — beta valid, held until accepted
- `beta_ready` in 1 — downstream accept
- `frame_err` out 1 — one-cycle pulse on tlast mismatch

## Operation
- **Input FIFOs.**
  - Two show-ahead FIFOs of DEPTH entries: {vin_data, vin_last} and {m_data, m_last}.
  - A write happens when valid & ready.
  - ready = not full. A pop in the same cycle does not free space for a write.
- **Pairing.** A pair pops both FIFOs when both are non-empty and the state is ACC. Pairs are never formed across frames.
- **Pipeline.**
  - P1 registers the A signed products vin × m[a], each VW+MW bits.
  - P2 sign-extends each product to ACCW and adds it into acc[a]. Accumulator overflow wraps at ACCW.
- **States.**
  - **ACC**:
    - A pop with both last flags = 1 → DRAIN.
    - A pop with the last flags unequal → `frame_err` pulses and the state goes to FLUSH. The popped pair is not accumulated, and the accumulators and pipeline are cleared.
  - **DRAIN**:
    - Waits 2 cycles for P1/P2 to empty.
    - Then loads the `beta` register and sets `beta_valid` → OUT.
  - **OUT**:
    - No pops; the FIFOs continue to accept writes.
    - On `beta_valid` & `beta_ready`: acc is cleared, `beta_valid` is cleared → ACC.
  - **FLUSH**:
    - Pops only the FIFO whose popped entry had last = 0.
    - Discards entries until one with last = 1 is popped, that entry included → ACC.
- **Output arithmetic.** beta[a] = acc[a] >>> SHIFT, reduced to BW per Configuration.
- **Reset** (asynchronous, any state, mid-frame included):
  - FIFOs empty, state ACC, acc and pipeline 0.
  - `beta` = 0, `beta_valid` = 0, `frame_err` = 0.
  - `vin_ready` = `m_ready` = 1 from the first cycle after release.

## Timing
- Write-to-pop: an entry written at edge t is poppable at t+1. No combinational input→output path.
- Last pair popped in cycle c → `beta_valid` = 1 in cycle c+3.
- `beta` is stable while `beta_valid` & !`beta_ready`.
- Earliest next pop after the beta handshake: the following cycle.
- `frame_err` is high for exactly the cycle after the mismatching pop.
- Throughput in ACC: 1 pair/cycle when both FIFOs are non-empty.
- A frame of N pairs occupies N + 3 cycles minimum, plus OUT dwell.

## Configuration
- **`CAL_CORE_MAC_SAT_EN` defined:** the shifted accumulator saturates to [−2^(BW−1), 2^(BW−1)−1].
- **Not defined:** the low BW bits of the shifted accumulator are taken (two's-complement wrap).
- All other behaviour is identical in both cases.

## Test plan
- **Basic frame.** A=4, SHIFT=0. vin = 1, 2, 3; each lane constant per frame, lanes 0..3 = 1, −1, 2, 10; last on the third entry of both streams. Required: beta lanes 0..3 = 6, −6, 12, 60, with `beta_valid` 3 cycles after the third pop.
- **Saturation / wrap.** Single pair vin = 100, all lanes m = 100, both last. Required: every lane = 127 with `CAL_CORE_MAC_SAT_EN` defined; 16 without it (10000 mod 256).
- **Back-pressure.**
  - Stimulus: `beta_ready` held low 40 cycles while both streams keep sending.
  - Required during the stall: `beta` stable; `vin_ready`/`m_ready` drop once each FIFO holds 16 entries.
  - Required after release: the next frames are bit-exact, with no lost or duplicated entries.
- **tlast mismatch.** `vin_last` on pair 2, `m_last` on pair 3. Required:
  - `frame_err` pulses once; no beta for that frame.
  - One M entry is flushed.
  - The following frame (vin = 2; lanes 0..3 = 3, 3, 3, 3; both last) gives beta = 6 in every lane.
- **Reset mid-frame.** Assert `rst_n` after 2 of 4 pairs are popped. Required:
  - `beta_valid` = 0 and FIFOs empty.
  - A new single-pair frame (vin = 5, all lanes m = 1) gives beta = 5 in every lane.
- **Skewed arrival.** M row arrives 10 cycles after vin (single pair, both last). Required: no pop until the M row is present; beta correct; `beta_valid` 3 cycles after the pop.
